// File: rtl/serial_xfer_pkg.sv
// rtl/serial_xfer_pkg.sv - shared mode selects and FSM encoding for the serial transfer unit
package serial_xfer_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/usr_cell.sv
// rtl/usr_cell.sv - one bit of the universal shift register: 4:1 mode mux feeding a clearable DFF
module usr_cell
  import serial_xfer_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] sel_i,
  input  logic       shr_i,
  input  logic       shl_i,
  input  logic       load_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel_i)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = shr_i;
      MODE_SHL:  q_d = shl_i;
      MODE_LOAD: q_d = load_i;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_xfer_ctrl.sv
// rtl/serial_xfer_ctrl.sv - load/shift/done controller over WIDTH usr_cells; SERIAL_XFER_ROTATE_EN adds circular shift via rot
module serial_xfer_ctrl
  import serial_xfer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
`ifdef SERIAL_XFER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [1:0]       sel,
  output logic             busy,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             done,
  output logic [WIDTH-1:0] par_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] par_q;
  logic             fill;

`ifdef SERIAL_XFER_ROTATE_EN
  logic rot_q, rot_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef SERIAL_XFER_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = dir;
`ifdef SERIAL_XFER_ROTATE_EN
          rot_d   = rot;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = CNT_W'(WIDTH);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        // the edge that sees a count of one performs the last of WIDTH shifts
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SERIAL_XFER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef SERIAL_XFER_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  always_comb begin
    sel = MODE_HOLD;
    case (state_q)
      ST_LOAD:  sel = MODE_LOAD;
      ST_SHIFT: sel = shift_mode(dir_q);
      default:  sel = MODE_HOLD;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign ser_valid = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign ser_out   = dir_q ? par_q[WIDTH-1] : par_q[0];
  assign par_out   = par_q;

`ifdef SERIAL_XFER_ROTATE_EN
  assign fill = rot_q ? ser_out : ser_in;
`else
  assign fill = ser_in;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shr_src;
    logic shl_src;

    if (i == WIDTH - 1) begin : g_shr_edge
      assign shr_src = fill;
    end else begin : g_shr_mid
      assign shr_src = par_q[i+1];
    end

    if (i == 0) begin : g_shl_edge
      assign shl_src = fill;
    end else begin : g_shl_mid
      assign shl_src = par_q[i-1];
    end

    usr_cell u_cell (
      .clk    (clk),
      .rstn   (rstn),
      .sel_i  (sel),
      .shr_i  (shr_src),
      .shl_i  (shl_src),
      .load_i (load_data[i]),
      .q_o    (par_q[i])
    );
  end

endmodule

// File: doc/serial_xfer_ctrl.md
Name: serial_xfer_ctrl

Overview:
- Serial transfer unit built around a WIDTH-bit universal shift register.
- The register is made of per-bit 4:1-mux/D-flip-flop cells, plus a controller FSM that drives the shared mode selects.
- Sequence: parallel-load a word, shift it out serially over exactly WIDTH clocks while shifting ser_in in, then signal done.
- Sits upstream of downstream serial consumers; it generates the S1/S0 mode selects the mux-DFF cells consume.

Parameters:
- WIDTH, 4: register width and number of shift cycles; legal range 2..16.
- CNT_W, $clog2(WIDTH+1): shift counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a transfer; sampled only in IDLE.
- dir  input  1  0 = shift right (LSB out first), 1 = shift left (MSB out first); latched at start.
- load_data  input  WIDTH  word loaded in the LOAD state.
- ser_in  input  1  serial fill bit; enters the MSB (right shift) or LSB (left shift).
- sel  output  2  current register mode {S1,S0}: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- busy  output  1  high whenever state != IDLE.
- ser_valid  output  1  high in SHIFT; ser_out is meaningful.
- ser_out  output  1  bit leaving the register: par_out[0] if dir_q=0, par_out[WIDTH-1] if dir_q=1.
- done  output  1  one-cycle pulse in DONE.
- par_out  output  WIDTH  register contents.

Behaviour:
- Reset (async, rstn=0): state IDLE, register 0, counter 0, dir_q 0. Outputs: sel 00, busy 0, ser_valid 0, done 0, ser_out 0, par_out 0.
- Reset mid-operation aborts immediately. No done pulse is issued.
- IDLE: sel=00 (hold). On a clock edge with start=1, latch dir_q=dir and go to LOAD.
- LOAD: sel=11. At the next edge, register <= load_data, counter <= WIDTH, go to SHIFT.
- SHIFT: sel=01 if dir_q=0, else 10. ser_valid=1.
  - Each edge shifts one position and decrements the counter.
  - When the counter reaches 1, the edge performs the final shift and moves to DONE.
  - Exactly WIDTH shifts occur.
- DONE: sel=00, done=1 for one cycle, then IDLE.
- Right shift: reg <= {fill, reg[WIDTH-1:1]}. Left shift: reg <= {reg[WIDTH-2:0], fill}. fill=ser_in unless rotating (see optional feature).
- ser_out is combinational from the register and dir_q. Downstream samples it on the edge that shifts it out.
- Latency: start sampled at edge 0 gives LOAD in cycle 1, SHIFT in cycles 2..WIDTH+1, done in cycle WIDTH+2.
- start while busy (including the DONE cycle) is ignored and not queued. dir and load_data changes after acceptance have no effect.
- load_data is sampled only at the LOAD edge.

Optional Feature:
- Macro: SERIAL_XFER_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit), latched with dir at start.
  - When rot_q=1, fill = the bit being shifted out (circular shift). After WIDTH shifts, par_out equals the loaded word.
  - When rot_q=0, fill = ser_in.
- Undefined: rot port is absent and fill is always ser_in.

Decomposition:
- Package serial_xfer_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - FSM state encoding ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE (2-bit).
- Sub-module usr_cell: one bit of the register.
  - 4:1 mux on sel choosing hold / right-neighbour / left-neighbour / load bit, feeding a DFF with async active-low clear.
  - Instantiated WIDTH times via generate. Edge cells take fill.

Test Plan:
- Reset values: rstn=0 for 2 cycles → sel=00, busy=0, done=0, par_out=0000, ser_out=0. Release, idle 3 cycles → all unchanged.
- Right shift: load_data=1011, dir=0, ser_in=0, start pulse → ser_out in SHIFT cycles = 1,1,0,1; done in cycle 6 after start edge; par_out=0000 at done.
- Left shift with fill: load_data=1011, dir=1, ser_in=1 → ser_out = 1,0,1,1; par_out=1111 at done; sel=10 throughout SHIFT.
- Start while busy: second start pulses in SHIFT and in DONE → exactly one done pulse; return to IDLE with no new LOAD.
- Reset mid-shift: assert rstn=0 after 2 shifts of 1011 → busy=0, par_out=0000, no done. A subsequent start completes normally.
- SERIAL_XFER_ROTATE_EN: load 1011, rot=1, dir=0 → ser_out = 1,1,0,1; par_out=1011 at done. Same run with rot=0 and ser_in=0 → 0000.
